// File: rtl/dash_entry_buffer_if.sv
// Bundle of entry-side controls and display-side results for dash_entry_buffer.
// With BACKSPACE_EN defined, the bundle also carries the backspace level.
interface dash_entry_buffer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  enter;
    logic                  clear;
    logic [3:0]            sw_in;
`ifdef BACKSPACE_EN
    logic                  backspace;
`endif
    logic [4*DIGITS-1:0]   char_codes;
    logic [2:0]            digit_count;
    logic                  full;
    logic                  entry_err;
    logic                  accept;

`ifdef BACKSPACE_EN
    modport master (
        output enter, clear, sw_in, backspace,
        input  char_codes, digit_count, full, entry_err, accept
    );
    modport slave (
        input  enter, clear, sw_in, backspace,
        output char_codes, digit_count, full, entry_err, accept
    );
`else
    modport master (
        output enter, clear, sw_in,
        input  char_codes, digit_count, full, entry_err, accept
    );
    modport slave (
        input  enter, clear, sw_in,
        output char_codes, digit_count, full, entry_err, accept
    );
`endif
endinterface

// File: rtl/dash_entry_buffer.sv
// Calculator-style digit entry buffer feeding the dash display; empty positions show DASH_CODE.
// Optional macro BACKSPACE_EN adds a backspace input that drops the rightmost digit.
module dash_entry_buffer #(
    parameter int unsigned DIGITS    = 4,
    parameter logic [3:0]  DASH_CODE = 4'hA,
    parameter int unsigned MAX_DIGIT = 9
) (
    input logic               clk,
    input logic               reset,
    dash_entry_buffer_if.slave bus
);
    localparam int unsigned Width     = 4 * DIGITS;
    localparam logic [3:0]  MaxDigit  = 4'(MAX_DIGIT);
    localparam logic [2:0]  LastCount = 3'(DIGITS - 1);
    localparam logic [Width-1:0] AllDash = {DIGITS{DASH_CODE}};

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e             state_q, state_d;
    logic [Width-1:0]   codes_q, codes_d;
    logic [2:0]         count_q, count_d;
    logic               full_q, full_d;
    logic               accept_q, accept_d;
    logic               err_q, err_d;
    logic               enter_q;
    logic               press;

    assign press = bus.enter & ~enter_q;

`ifdef BACKSPACE_EN
    logic backspace_q;
    logic bs_press;
    assign bs_press = bus.backspace & ~backspace_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEmpty;
            codes_q  <= AllDash;
            count_q  <= 3'd0;
            full_q   <= 1'b0;
            accept_q <= 1'b0;
            err_q    <= 1'b0;
            // Start high so a level held through reset is not seen as a press.
            enter_q  <= 1'b1;
`ifdef BACKSPACE_EN
            backspace_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            codes_q  <= codes_d;
            count_q  <= count_d;
            full_q   <= full_d;
            accept_q <= accept_d;
            err_q    <= err_d;
            enter_q  <= bus.enter;
`ifdef BACKSPACE_EN
            backspace_q <= bus.backspace;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        codes_d  = codes_q;
        count_d  = count_q;
        full_d   = full_q;
        accept_d = 1'b0;
        err_d    = 1'b0;

        if (bus.clear) begin
            state_d = StEmpty;
            codes_d = AllDash;
            count_d = 3'd0;
            full_d  = 1'b0;
        end
`ifdef BACKSPACE_EN
        else if (bs_press) begin
            // Backspace wins over a coincident Enter press; the press is dropped.
            if (state_q == StEmpty) begin
                err_d = 1'b1;
            end else begin
                codes_d = {DASH_CODE, codes_q[Width-1:4]};
                count_d = count_q - 3'd1;
                state_d = (count_q == 3'd1) ? StEmpty : StPartial;
                full_d  = 1'b0;
            end
        end
`endif
        else if (press) begin
            unique case (state_q)
                StEmpty, StPartial: begin
                    if (bus.sw_in <= MaxDigit) begin
                        codes_d  = {codes_q[Width-5:0], bus.sw_in};
                        count_d  = count_q + 3'd1;
                        state_d  = (count_q == LastCount) ? StFull : StPartial;
                        full_d   = (count_q == LastCount);
                        accept_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StFull:  err_d = 1'b1;
                default: err_d = 1'b0;
            endcase
        end
    end

    assign bus.char_codes  = codes_q;
    assign bus.digit_count = count_q;
    assign bus.full        = full_q;
    assign bus.accept      = accept_q;
    assign bus.entry_err   = err_q;

endmodule

// File: tb/tb_dash_entry_buffer.sv
// Self-checking bench for dash_entry_buffer: fixed vector table, corner sequences and
// randomized traffic against a digit-queue reference model.
module tb_dash_entry_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dash_entry_buffer_if #(.DIGITS(4)) bus ();

    dash_entry_buffer #(
        .DIGITS(4),
        .DASH_CODE(4'hA),
        .MAX_DIGIT(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the digits held, oldest first.
    logic [3:0] m_digits[$];
    bit m_last_enter = 1'b1;
    bit m_last_bs = 1'b1;
    bit m_acc = 1'b0;
    bit m_err = 1'b0;

    typedef struct {
        logic       enter;
        logic       clear;
        logic [3:0] sw;
        logic [15:0] codes;
        logic [2:0] count;
        logic       full;
        logic       acc;
        logic       err;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_codes();
        logic [15:0] c;
        int n;
        c = 16'hAAAA;
        n = m_digits.size();
        for (int i = 0; i < n; i++) c[4*i +: 4] = m_digits[n-1-i];
        return c;
    endfunction

    task automatic model_step();
        bit press;
        bit bs_press;
        if (reset) begin
            m_digits.delete();
            m_last_enter = 1'b1;
            m_last_bs = 1'b1;
            m_acc = 1'b0;
            m_err = 1'b0;
        end else begin
            press = bus.enter && !m_last_enter;
            m_last_enter = bus.enter;
            bs_press = 1'b0;
`ifdef BACKSPACE_EN
            bs_press = bus.backspace && !m_last_bs;
            m_last_bs = bus.backspace;
`endif
            m_acc = 1'b0;
            m_err = 1'b0;
            if (bus.clear) begin
                m_digits.delete();
            end else if (bs_press) begin
                if (m_digits.size() == 0) m_err = 1'b1;
                else void'(m_digits.pop_back());
            end else if (press) begin
                if (m_digits.size() == 4 || bus.sw_in > 4'd9) begin
                    m_err = 1'b1;
                end else begin
                    m_digits.push_back(bus.sw_in);
                    m_acc = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_codes", bus.char_codes, m_codes());
        check("model_count", 16'(bus.digit_count), 16'(m_digits.size()));
        check("model_full", 16'(bus.full), 16'(m_digits.size() == 4));
        check("model_accept", 16'(bus.accept), 16'(m_acc));
        check("model_err", 16'(bus.entry_err), 16'(m_err));
    endtask

    task automatic drive(input logic e, input logic c, input logic [3:0] s);
        bus.enter = e;
        bus.clear = c;
        bus.sw_in = s;
    endtask

    task automatic press_digit(input logic [3:0] s);
        drive(1'b1, 1'b0, s);
        tick();
        drive(1'b0, 1'b0, s);
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 4'h0, 16'hAAAA, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'h1, 16'hAAA1, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h1, 16'hAAA1, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'h2, 16'hAA12, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h2, 16'hAA12, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'h3, 16'hA123, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h3, 16'hA123, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'h4, 16'h1234, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h4, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'h7, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'h7, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 16'hAAAA, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'h1, 16'hAAA1, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'h1, 16'hAAA1, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'h2, 16'hAA12, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'h2, 16'hAA12, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'hC, 16'hAA12, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 4'hC, 16'hAA12, 3'd2, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 4'h0);
`ifdef BACKSPACE_EN
        bus.backspace = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("idle_codes", bus.char_codes, 16'hAAAA);
        check("idle_count", 16'(bus.digit_count), 16'd0);
        check("idle_full", 16'(bus.full), 16'd0);
        check("idle_pulses", 16'({bus.accept, bus.entry_err}), 16'd0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].enter, vecs[i].clear, vecs[i].sw);
            tick();
            check($sformatf("vec%0d_codes", i), bus.char_codes, vecs[i].codes);
            check($sformatf("vec%0d_count", i), 16'(bus.digit_count), 16'(vecs[i].count));
            check($sformatf("vec%0d_full", i), 16'(bus.full), 16'(vecs[i].full));
            check($sformatf("vec%0d_accept", i), 16'(bus.accept), 16'(vecs[i].acc));
            check($sformatf("vec%0d_err", i), 16'(bus.entry_err), 16'(vecs[i].err));
        end

        // Held Enter: one store only.
        drive(1'b1, 1'b0, 4'h5);
        tick();
        check("held_first_accept", 16'(bus.accept), 16'd1);
        for (int i = 0; i < 19; i++) begin
            tick();
            check("held_no_accept", 16'(bus.accept), 16'd0);
        end
        check("held_codes", bus.char_codes, 16'hA125);
        check("held_count", 16'(bus.digit_count), 16'd3);
        drive(1'b0, 1'b0, 4'h5);
        tick();

        // Clear beats a coincident press.
        drive(1'b1, 1'b1, 4'h8);
        tick();
        check("clr_press_codes", bus.char_codes, 16'hAAAA);
        check("clr_press_count", 16'(bus.digit_count), 16'd0);
        check("clr_press_accept", 16'(bus.accept), 16'd0);
        check("clr_press_err", 16'(bus.entry_err), 16'd0);
        drive(1'b0, 1'b0, 4'h8);
        tick();

        // Enter held across reset is not a press.
        press_digit(4'h3);
        drive(1'b1, 1'b0, 4'h6);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_held_codes", bus.char_codes, 16'hAAAA);
            check("rst_held_accept", 16'(bus.accept), 16'd0);
        end
        drive(1'b0, 1'b0, 4'h6);
        tick();
        drive(1'b1, 1'b0, 4'h6);
        tick();
        check("rst_repress_codes", bus.char_codes, 16'hAAA6);
        check("rst_repress_accept", 16'(bus.accept), 16'd1);
        drive(1'b0, 1'b0, 4'h6);
        tick();

`ifdef BACKSPACE_EN
        drive(1'b0, 1'b1, 4'h0);
        tick();
        press_digit(4'h1);
        press_digit(4'h2);
        press_digit(4'h3);
        press_digit(4'h4);
        check("bs_pre_codes", bus.char_codes, 16'h1234);
        bus.backspace = 1'b1;
        tick();
        check("bs_codes", bus.char_codes, 16'hA123);
        check("bs_full", 16'(bus.full), 16'd0);
        check("bs_count", 16'(bus.digit_count), 16'd3);
        bus.backspace = 1'b0;
        drive(1'b0, 1'b1, 4'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0);
        bus.backspace = 1'b1;
        tick();
        check("bs_empty_err", 16'(bus.entry_err), 16'd1);
        check("bs_empty_codes", bus.char_codes, 16'hAAAA);
        bus.backspace = 1'b0;
        tick();
`endif

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                  4'($urandom_range(0, 11)));
`ifdef BACKSPACE_EN
            bus.backspace = ($urandom_range(0, 5) == 0);
`endif
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dash_entry_buffer.md
Name: dash_entry_buffer

Overview:
Upstream feeder for the 4-digit seven-segment dash display. It builds a four-character code word from operator entry.
- Each press of the debounced Enter level samples the 4-bit switch value and shifts it in from the right, calculator style.
- Positions not yet filled hold the dash code.
- The packed 16-bit word goes to the display scanner, which slices it per anode in the same order as its anode pattern: [15:12] is the leftmost digit.

Parameters:
DIGITS, 4, number of character positions (fixed 4 for this board; packed width = 4*DIGITS)
DASH_CODE, 4'hA, character code rendered as a dash by character_to_segment
MAX_DIGIT, 9, largest switch value accepted as a digit

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enter  input  1  debounced Enter level (debouncer clean_out); block does its own edge detection
clear  input  1  level; return buffer to all dashes
sw_in  input  4  digit value sampled on Enter
char_codes  output  16  packed character codes, [15:12] leftmost ... [3:0] rightmost
digit_count  output  3  number of digits currently held, 0..4
full  output  1  high when digit_count == 4
entry_err  output  1  one-cycle pulse: Enter rejected
accept  output  1  one-cycle pulse: digit stored

Behaviour:
- One clock domain. Reset is synchronous, active-high, and sampled on posedge clk. All outputs are registered.
- Reset values:
  - char_codes = 16'hAAAA
  - digit_count = 0, full = 0, entry_err = 0, accept = 0
  - internal enter_q = 1, so an Enter held through reset is not counted as a press.
- Edge detect: press = enter & ~enter_q; enter_q <= enter every cycle.
- States:
  - EMPTY (count 0)
  - PARTIAL (count 1..3)
  - FULL (count 4)
- Transitions:
  - EMPTY/PARTIAL + press + sw_in <= MAX_DIGIT:
    - char_codes <= {char_codes[11:0], sw_in}; count+1; accept=1 next cycle.
    - Entering the 4th digit moves to FULL, with full=1 in the same update.
  - EMPTY/PARTIAL + press + sw_in > MAX_DIGIT: no store, count unchanged, entry_err=1 for one cycle.
  - FULL + press: ignored. No shift, no accept, entry_err=1 for one cycle.
  - Any state + clear: char_codes <= 16'hAAAA, count 0, full 0 → EMPTY.
- Latency: a press sampled at edge N appears on char_codes/digit_count/accept after edge N, i.e. valid in cycle N+1.
- Pulses: accept and entry_err are mutually exclusive and last exactly one cycle per press.
- Held Enter: produces exactly one press until enter returns low for at least one cycle.
- Simultaneous events:
  - clear + press in the same cycle: clear wins, press discarded, no pulse.
  - reset dominates everything.
- Reset mid-entry: the buffer returns to all dashes on the next edge. Partial digits are lost.
- Invariant: positions left of the entered digits always hold DASH_CODE, i.e. char_codes[15:4*count] == DASH repeated.

Optional Feature:
Macro BACKSPACE_EN.
- Defined:
  - Adds input port `backspace` (1 bit, debounced level), with its own edge detector (reset value 1).
  - A rising edge with count > 0 sets char_codes <= {DASH_CODE, char_codes[15:4]} and count-1; FULL → PARTIAL and full clears.
  - A rising edge at count 0 raises entry_err for one cycle.
  - Priority: reset > clear > backspace > enter. A backspace edge coinciding with an enter press discards the press.
- Undefined: no backspace port; behaviour exactly as above.

Test Plan:
- Reset, then idle 10 cycles → char_codes=16'hAAAA, digit_count=0, full=0, no pulses.
- Presses with sw_in=1,2,3 → char_codes 16'hAAA1, 16'hAA12, 16'hA123 after each; accept pulses 3×, one cycle each.
- 4th press sw_in=4 → 16'h1234, full=1. 5th press sw_in=7 → unchanged, entry_err one cycle.
- From 16'hAA12, press with sw_in=4'hC → no change, count 2, entry_err pulse. Hold enter high 20 cycles with sw_in=5 → exactly one store, 16'hA125.
- clear asserted in the same cycle as a press with sw_in=8 → 16'hAAAA, count 0, no accept. Reset asserted with enter held high, then released with enter still high → no store until enter falls and rises again.
- BACKSPACE_EN: 16'h1234 + backspace → 16'hA123, full=0, count 3. Backspace at count 0 → entry_err pulse, 16'hAAAA.
